// File: rtl/fg_pkg.sv
// Shared types and constants for the DDS sample-rate scheduler.
package fg_pkg;

    localparam int unsigned MODE_W    = 3;
    localparam int unsigned NUM_MODES = 5;
    localparam int unsigned DIV_W     = 15;
    localparam int unsigned OVR_W     = 8;

    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t MODE_MAX = 3'd4;

    localparam logic [NUM_MODES-1:0][DIV_W-1:0] DIV_TABLE =
        {15'd10000, 15'd1000, 15'd100, 15'd10, 15'd0};

    localparam logic [OVR_W-1:0] OVR_MAX = 8'd255;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    // Divisor for a mode; out-of-range codes fall back to the fastest rate.
    function automatic logic [DIV_W-1:0] div_of(input mode_t m);
        case (m)
            3'd1:    return DIV_TABLE[1];
            3'd2:    return DIV_TABLE[2];
            3'd3:    return DIV_TABLE[3];
            3'd4:    return DIV_TABLE[4];
            default: return DIV_TABLE[0];
        endcase
    endfunction

endpackage

// File: rtl/fg_sample_scheduler_if.sv
// Sample request/acknowledge channel between the scheduler and the DAC datapath.
interface fg_sample_scheduler_if;
    import fg_pkg::*;

    logic             Sample_req;
    logic             Dac_ack;
    logic             Overrun;
    logic [OVR_W-1:0] Ovr_count;

    modport master (
        output Sample_req,
        output Overrun,
        output Ovr_count,
        input  Dac_ack
    );

    modport slave (
        input  Sample_req,
        input  Overrun,
        input  Ovr_count,
        output Dac_ack
    );

endinterface

// File: rtl/fg_btn_debounce.sv
// Mode button conditioning: 2-flop synchronizer, optional debounce filter
// (FG_SCHED_DEBOUNCE_EN), and a one-cycle rising-edge pulse.
module fg_btn_debounce #(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic Fg_clk,
    input  logic Resetn,
    input  logic btn,
    output logic rise_c
);

    if (DEB_CYCLES < 2) begin : g_deb_check
        $error("DEB_CYCLES must be at least 2");
    end

    logic sync1;
    logic sync2;
    logic level;
    logic level_q;

    always_ff @(posedge Fg_clk or negedge Resetn) begin
        if (!Resetn) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

`ifdef FG_SCHED_DEBOUNCE_EN
    localparam int unsigned DEB_W = $clog2(DEB_CYCLES);

    logic [DEB_W-1:0] deb_cnt;
    logic             deb_level;

    // Accept a new level only after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge Fg_clk or negedge Resetn) begin
        if (!Resetn) begin
            deb_cnt   <= '0;
            deb_level <= 1'b0;
        end else if (sync2 == deb_level) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
            deb_cnt   <= '0;
            deb_level <= sync2;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    assign level = deb_level;
`else
    assign level = sync2;
`endif

    always_ff @(posedge Fg_clk or negedge Resetn) begin
        if (!Resetn) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign rise_c = level & ~level_q;

endmodule

// File: rtl/fg_sample_scheduler.sv
// Sample-rate scheduler: startup delay, button-driven mode select, period
// ticking and req/ack handshake with overrun tracking. Debounce via FG_SCHED_DEBOUNCE_EN.
module fg_sample_scheduler
    import fg_pkg::*;
#(
    parameter int unsigned STARTUP_CYCLES = 79,
    parameter int unsigned DEB_CYCLES     = 16,
    parameter int unsigned CNT_W          = 15
) (
    input  logic                  Fg_clk,
    input  logic                  Resetn,
    input  logic                  IntBtn,
    fg_sample_scheduler_if.master dac,
    output logic                  Ready,
    output mode_t                 Mode
);

    localparam int unsigned ST_W = $clog2(STARTUP_CYCLES + 1);

    logic [ST_W-1:0]  st_cnt;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] div_c;
    logic             rise_c;
    logic             tick_c;
    logic             ovr_set_c;
    state_t           state;
    state_t           state_nxt;

    fg_btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_btn (
        .Fg_clk (Fg_clk),
        .Resetn (Resetn),
        .btn    (IntBtn),
        .rise_c (rise_c)
    );

    // Startup delay; Ready is sticky until the next reset.
    always_ff @(posedge Fg_clk or negedge Resetn) begin
        if (!Resetn) begin
            st_cnt <= '0;
            Ready  <= 1'b0;
        end else if (!Ready) begin
            st_cnt <= st_cnt + 1'b1;
            if (st_cnt == ST_W'(STARTUP_CYCLES - 1)) begin
                Ready <= 1'b1;
            end
        end
    end

    always_ff @(posedge Fg_clk or negedge Resetn) begin
        if (!Resetn) begin
            Mode <= '0;
        end else if (rise_c) begin
            Mode <= (Mode == MODE_MAX) ? '0 : Mode + 1'b1;
        end
    end

    assign div_c  = CNT_W'(div_of(Mode));
    // A mode change restarts the period and suppresses the tick on that edge.
    assign tick_c = Ready & (per_cnt == div_c) & ~rise_c;

    always_ff @(posedge Fg_clk or negedge Resetn) begin
        if (!Resetn) begin
            per_cnt <= '0;
        end else if (!Ready || rise_c || tick_c) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + 1'b1;
        end
    end

    always_ff @(posedge Fg_clk or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tick_c) state_nxt = REQ;
            REQ:     if (dac.Dac_ack && !tick_c) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A tick that finds the previous request unacknowledged is an overrun.
    always_comb begin
        ovr_set_c = 1'b0;
        if (state == REQ && !dac.Dac_ack && tick_c) begin
            ovr_set_c = 1'b1;
        end
    end

    always_ff @(posedge Fg_clk or negedge Resetn) begin
        if (!Resetn) begin
            dac.Overrun   <= 1'b0;
            dac.Ovr_count <= '0;
        end else begin
            dac.Overrun <= ovr_set_c;
            if (ovr_set_c && dac.Ovr_count != OVR_MAX) begin
                dac.Ovr_count <= dac.Ovr_count + 1'b1;
            end
        end
    end

    assign dac.Sample_req = (state == REQ);

endmodule

// File: tb/tb_fg_sample_scheduler.sv
// Self-checking bench for fg_sample_scheduler against a behavioural model of
// the scheduling rules; honours FG_SCHED_DEBOUNCE_EN for button latency.
module tb_fg_sample_scheduler;

    localparam int STARTUP = 79;
    localparam int DEB     = 16;
`ifdef FG_SCHED_DEBOUNCE_EN
    localparam bit DEB_EN = 1'b1;
`else
    localparam bit DEB_EN = 1'b0;
`endif

    logic       Fg_clk = 1'b0;
    logic       Resetn = 1'b0;
    logic       IntBtn = 1'b0;
    logic       Ready;
    logic [2:0] Mode;

    fg_sample_scheduler_if dac_if ();

    fg_sample_scheduler #(
        .STARTUP_CYCLES(STARTUP),
        .DEB_CYCLES    (DEB),
        .CNT_W         (15)
    ) dut (
        .Fg_clk (Fg_clk),
        .Resetn (Resetn),
        .IntBtn (IntBtn),
        .dac    (dac_if),
        .Ready  (Ready),
        .Mode   (Mode)
    );

    always #5 Fg_clk = ~Fg_clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int             divs [5] = '{0, 10, 100, 1000, 10000};
    int             m_edges   = 0;
    int             m_mode    = 0;
    int             m_cnt     = 0;
    bit             m_pend    = 1'b0;
    bit             m_ovr     = 1'b0;
    int             m_ovr_cnt = 0;
    logic [DEB+3:0] m_hist    = '0;
    bit             m_deb     = 1'b0;
    bit             m_deb_prev = 1'b0;

    // m_hist[i] holds IntBtn as sampled i+1 edges ago.
    always @(posedge Fg_clk or negedge Resetn) begin : model
        bit rdy;
        bit rise;
        bit tick;
        if (!Resetn) begin
            m_edges    = 0;
            m_mode     = 0;
            m_cnt      = 0;
            m_pend     = 1'b0;
            m_ovr      = 1'b0;
            m_ovr_cnt  = 0;
            m_hist     = '0;
            m_deb      = 1'b0;
            m_deb_prev = 1'b0;
        end else begin
            rdy  = (m_edges >= STARTUP);
            rise = DEB_EN ? (m_deb && !m_deb_prev) : (m_hist[1] && !m_hist[2]);
            tick = rdy && (m_cnt == divs[m_mode]) && !rise;
            m_ovr = m_pend && !dac_if.Dac_ack && tick;
            if (m_ovr && m_ovr_cnt < 255) m_ovr_cnt++;
            if (!m_pend) m_pend = tick;
            else if (dac_if.Dac_ack && !tick) m_pend = 1'b0;
            m_cnt = (!rdy || rise || tick) ? 0 : m_cnt + 1;
            if (rise) m_mode = (m_mode + 1) % 5;
            m_deb_prev = m_deb;
            if (m_hist[DEB:1] == {DEB{~m_deb}}) m_deb = ~m_deb;
            m_hist = {m_hist[DEB+2:0], IntBtn};
            if (m_edges < STARTUP) m_edges++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("ready",      32'(Ready),             32'(m_edges >= STARTUP));
        chk("mode",       32'(Mode),              32'(m_mode));
        chk("sample_req", 32'(dac_if.Sample_req), 32'(m_pend));
        chk("overrun",    32'(dac_if.Overrun),    32'(m_ovr));
        chk("ovr_count",  32'(dac_if.Ovr_count),  32'(m_ovr_cnt));
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge Fg_clk);
            chk_all();
        end
    endtask

    task automatic press(input int hold, input int gap);
        IntBtn = 1'b1;
        cyc(hold);
        IntBtn = 1'b0;
        cyc(gap);
    endtask

    initial begin
        int reqs;
        int run;
        int presses;

        dac_if.Dac_ack = 1'b1;
        cyc(3);
        Resetn = 1'b1;

        // Startup delay
        cyc(STARTUP - 1);
        chk("ready_before_79", 32'(Ready), 32'd0);
        chk("req_before_ready", 32'(dac_if.Sample_req), 32'd0);
        cyc(1);
        chk("ready_at_79", 32'(Ready), 32'd1);

        // Mode 0, ack tied high: continuous requests, no overruns
        cyc(20);
        chk("mode0_req_high", 32'(dac_if.Sample_req), 32'd1);
        chk("mode0_no_ovr", 32'(dac_if.Ovr_count), 32'd0);

        // Five clean presses cycle the mode 1,2,3,4,0
        for (int p = 0; p < 5; p++) begin
            press(20, 30);
            chk("press_mode", 32'(Mode), 32'((p + 1) % 5));
        end

        // Mode 1 with ack high: one request per 11 cycles
        press(20, 30);
        chk("mode1_sel", 32'(Mode), 32'd1);
        reqs = 0;
        for (int i = 0; i < 44; i++) begin
            cyc(1);
            if (dac_if.Sample_req) reqs++;
        end
        chk("mode1_rate", 32'(reqs), 32'd4);

        // Mode 1 with ack withheld: overruns accumulate, request stays up
        dac_if.Dac_ack = 1'b0;
        cyc(50);
        chk("mode1_req_held", 32'(dac_if.Sample_req), 32'd1);
        dac_if.Dac_ack = 1'b1;
        cyc(3);

        // Short glitch: filtered only when the debouncer is present
        press(5, 30);
        chk("glitch_mode", 32'(Mode), DEB_EN ? 32'd1 : 32'd2);

        // Back to mode 0, then starve acks until the counter saturates
        presses = (5 - m_mode) % 5;
        repeat (presses) press(20, 30);
        chk("back_to_mode0", 32'(Mode), 32'd0);
        dac_if.Dac_ack = 1'b0;
        cyc(300);
        chk("ovr_saturated", 32'(dac_if.Ovr_count), 32'd255);

        // Mid-run reset clears everything immediately
        #2 Resetn = 1'b0;
        #1;
        chk("rst_ready",     32'(Ready),             32'd0);
        chk("rst_mode",      32'(Mode),              32'd0);
        chk("rst_req",       32'(dac_if.Sample_req), 32'd0);
        chk("rst_overrun",   32'(dac_if.Overrun),    32'd0);
        chk("rst_ovr_count", 32'(dac_if.Ovr_count),  32'd0);
        cyc(2);
        Resetn = 1'b1;
        dac_if.Dac_ack = 1'b1;
        cyc(STARTUP - 1);
        chk("restart_ready_before", 32'(Ready), 32'd0);
        cyc(1);
        chk("restart_ready_at", 32'(Ready), 32'd1);

        // Randomised ack and button activity
        run = 0;
        for (int i = 0; i < 700; i++) begin
            dac_if.Dac_ack = ($urandom_range(0, 3) != 0);
            if (run == 0) begin
                IntBtn = ~IntBtn;
                run = $urandom_range(3, 40);
            end else begin
                run--;
            end
            cyc(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
